// File: rtl/div_iter_radix.sv
// Iterative restoring integer divider retiring RADIX_BITS quotient bits per cycle.
// Handles DIV/DIVU/REM/REMU and word variants, with valid/ready handshakes and flush.
module div_iter_radix #(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            div_sign,
    input  logic            div_word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            busy
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN / RADIX_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(XLEN / RADIX_BITS);
    localparam logic [CW-1:0] CNT_WORD = CW'(HALF / RADIX_BITS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic [XLEN-1:0] sextWord(input logic [HALF-1:0] x);
        return {{HALF{x[HALF-1]}}, x};
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] prem_q, prem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            word_q, word_d;
    logic            negQuot_q, negQuot_d;
    logic            negRem_q, negRem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic [XLEN-1:0] opA, opB, magA, magB, minNeg;
    logic            negA, negB, divZero, overflow;
    logic [XLEN-1:0] remStep, quoStep;
    logic [XLEN-1:0] qRaw, qSigned, rSigned;

    // Operands are extended to XLEN first so one magnitude path serves both widths.
    always_comb begin
        opA = rs1_data;
        opB = rs2_data;
        if (div_word) begin
            opA = div_sign ? sextWord(rs1_data[HALF-1:0]) : {{HALF{1'b0}}, rs1_data[HALF-1:0]};
            opB = div_sign ? sextWord(rs2_data[HALF-1:0]) : {{HALF{1'b0}}, rs2_data[HALF-1:0]};
        end
        negA     = div_sign & opA[XLEN-1];
        negB     = div_sign & opB[XLEN-1];
        magA     = negA ? -opA : opA;
        magB     = negB ? -opB : opB;
        minNeg   = div_word ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                            : {1'b1, {(XLEN - 1){1'b0}}};
        divZero  = (opB == '0);
        overflow = div_sign & (opA == minNeg) & (opB == '1);
    end

    // The trial value is one bit wider than the stored remainder to catch the borrow.
    always_comb begin
        logic [XLEN:0] trial;
        logic [XLEN:0] diff;
        remStep = prem_q;
        quoStep = quo_q;
        trial   = '0;
        diff    = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            trial   = {remStep, quoStep[XLEN-1]};
            diff    = trial - {1'b0, divisor_q};
            quoStep = {quoStep[XLEN-2:0], ~diff[XLEN]};
            remStep = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

    always_comb begin
        qRaw    = word_q ? {{HALF{1'b0}}, quo_q[HALF-1:0]} : quo_q;
        qSigned = negQuot_q ? -qRaw : qRaw;
        rSigned = negRem_q ? -prem_q : prem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        word_d    = word_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        quot_d    = quot_q;
        rem_d     = rem_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        word_d    = div_word;
                        negQuot_d = negA ^ negB;
                        negRem_d  = negA;
                        if (divZero) begin
                            state_d = DONE;
                            quot_d  = '1;
                            rem_d   = div_word ? sextWord(rs1_data[HALF-1:0]) : rs1_data;
                        end else if (overflow) begin
                            state_d = DONE;
                            quot_d  = opA;
                            rem_d   = '0;
                        end else begin
                            state_d   = CALC;
                            cnt_d     = div_word ? CNT_WORD : CNT_FULL;
                            prem_d    = '0;
                            divisor_d = magB;
                            // Word dividends sit in the top half so the MSB feed is uniform.
                            quo_d     = div_word ? {magA[HALF-1:0], {HALF{1'b0}}} : magA;
                        end
                    end
                end
                CALC: begin
                    prem_d = remStep;
                    quo_d  = quoStep;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    quot_d  = word_q ? sextWord(qSigned[HALF-1:0]) : qSigned;
                    rem_d   = word_q ? sextWord(rSigned[HALF-1:0]) : rSigned;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            word_q    <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            word_q    <= word_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign quot      = quot_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_div_iter_radix.sv
// Directed and random scoreboard bench for div_iter_radix (XLEN=64, RADIX_BITS=2).
// Expected results come from constants or a native-arithmetic reference model.
module tb_div_iter_radix;

    localparam int XLEN       = 64;
    localparam int RADIX_BITS = 2;
    localparam int HALF       = XLEN / 2;
    localparam int LAT_FULL   = XLEN / RADIX_BITS + 2;
    localparam int LAT_WORD   = HALF / RADIX_BITS + 2;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        divSign = 1'b0;
    logic        divWord = 1'b0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [63:0] quot;
    logic [63:0] rem;
    logic        busy;

    expEntry_t   expQ[$];
    string       tagQ[$];
    int          passCount = 0;
    int          checkCount = 0;

    div_iter_radix #(.XLEN(XLEN), .RADIX_BITS(RADIX_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (inValid),
        .in_ready (inReady),
        .div_sign (divSign),
        .div_word (divWord),
        .rs1_data (rs1),
        .rs2_data (rs2),
        .out_valid(outValid),
        .out_ready(outReady),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void refDiv(input logic s, input logic w, input logic [63:0] a,
                                   input logic [63:0] b, output logic [63:0] q,
                                   output logic [63:0] r, output logic special);
        logic [31:0] a32, b32, uq, ur;
        int          sa, sb, qq, rr;
        longint      la, lb, lq, lr;
        a32 = a[31:0];
        b32 = b[31:0];
        special = 1'b0;
        if (w) begin
            if (b32 == 32'h0) begin
                q = '1;
                r = {{32{a32[31]}}, a32};
                special = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q = {{32{a32[31]}}, a32};
                r = '0;
                special = 1'b1;
            end else if (s) begin
                sa = a32;
                sb = b32;
                qq = sa / sb;
                rr = sa % sb;
                lq = qq;
                lr = rr;
                q = lq;
                r = lr;
            end else begin
                uq = a32 / b32;
                ur = a32 % b32;
                q = {{32{uq[31]}}, uq};
                r = {{32{ur[31]}}, ur};
            end
        end else begin
            if (b == 64'h0) begin
                q = '1;
                r = a;
                special = 1'b1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = '0;
                special = 1'b1;
            end else if (s) begin
                la = a;
                lb = b;
                lq = la / lb;
                lr = la % lb;
                q = lq;
                r = lr;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    task automatic applyStimulus(input logic s, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] eq,
                                 input logic [63:0] er, input int lat, input string tag);
        expEntry_t e;
        checkVal({tag, " inReadyBefore"}, {63'd0, inReady}, 64'd1);
        divSign = s;
        divWord = w;
        rs1 = a;
        rs2 = b;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        e.q = eq;
        e.r = er;
        e.lat = lat;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput(input int holdCycles);
        int        waited;
        expEntry_t e;
        string     tag;
        waited = 0;
        while (outValid !== 1'b1 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        e = expQ.pop_front();
        tag = tagQ.pop_front();
        checkVal({tag, " outValid"}, {63'd0, outValid}, 64'd1);
        checkVal({tag, " latencyCycle"}, 64'(waited + 1), 64'(e.lat));
        checkVal({tag, " quot"}, quot, e.q);
        checkVal({tag, " rem"}, rem, e.r);
        checkVal({tag, " inReadyInDone"}, {63'd0, inReady}, 64'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkVal({tag, " holdValid"}, {63'd0, outValid}, 64'd1);
            checkVal({tag, " holdQuot"}, quot, e.q);
            checkVal({tag, " holdRem"}, rem, e.r);
            checkVal({tag, " holdInReady"}, {63'd0, inReady}, 64'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkVal({tag, " validDropped"}, {63'd0, outValid}, 64'd0);
        checkVal({tag, " inReadyAfter"}, {63'd0, inReady}, 64'd1);
    endtask

    task automatic watchNoValid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (outValid === 1'b1) seen++;
        end
        checkVal({tag, " noValidCycles"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] rq, rr, ra, rb;
        logic        sp, rs, rw;

        $display("[TB] starting div_iter_radix bench");
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset inReady", {63'd0, inReady}, 64'd1);
        checkVal("reset outValid", {63'd0, outValid}, 64'd0);
        checkVal("reset busy", {63'd0, busy}, 64'd0);
        checkVal("reset quot", quot, 64'd0);
        checkVal("reset rem", rem, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL, "signedNeg7by2");
        checkOutput(5);

        applyStimulus(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                      64'h5555_5555_5555_5555, 64'd0, LAT_FULL, "unsignedMaxBy3");
        checkOutput(0);

        applyStimulus(1'b0, 1'b0, 64'h1234, 64'd0,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, "divuByZero");
        checkOutput(0);

        applyStimulus(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'h8000_0000_0000_0000, 64'd0, 1, "signedOverflow");
        checkOutput(0);

        applyStimulus(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'hFFFF_FFFF_8000_0000, 64'd0, 1, "wordOverflow");
        checkOutput(0);

        applyStimulus(1'b0, 1'b1, 64'hABCD_0000_0000_0064, 64'd7,
                      64'd14, 64'd2, LAT_WORD, "wordUnsigned100by7");
        checkOutput(0);

        applyStimulus(1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, LAT_WORD, "wordSignedNeg7by2");
        checkOutput(0);

        applyStimulus(1'b0, 1'b1, 64'h0000_0000_F000_0000, 64'd1,
                      64'hFFFF_FFFF_F000_0000, 64'd0, LAT_WORD, "divuwSignExtend");
        checkOutput(0);

        // Flush in the tenth CALC cycle; the pending expectation is withdrawn.
        applyStimulus(1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, LAT_FULL, "flushVictim");
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(expQ.pop_back());
        void'(tagQ.pop_back());
        checkVal("flush busy", {63'd0, busy}, 64'd0);
        checkVal("flush inReady", {63'd0, inReady}, 64'd1);
        watchNoValid("flush", 40);
        applyStimulus(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, LAT_FULL, "afterFlush100by7");
        checkOutput(0);

        applyStimulus(1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, LAT_FULL, "rstVictim");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(expQ.pop_back());
        void'(tagQ.pop_back());
        checkVal("rst busy", {63'd0, busy}, 64'd0);
        checkVal("rst inReady", {63'd0, inReady}, 64'd1);
        checkVal("rst outValid", {63'd0, outValid}, 64'd0);
        checkVal("rst quot", quot, 64'd0);
        checkVal("rst rem", rem, 64'd0);
        watchNoValid("rst", 40);
        applyStimulus(1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, LAT_FULL, "afterRst100by7");
        checkOutput(0);

        // A request presented together with flush must be ignored.
        divSign = 1'b0;
        divWord = 1'b0;
        rs1 = 64'h55;
        rs2 = 64'd0;
        inValid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        flush = 1'b0;
        checkVal("flushIdle busy", {63'd0, busy}, 64'd0);
        checkVal("flushIdle outValid", {63'd0, outValid}, 64'd0);

        // Flush beats out_ready in DONE and the result is dropped.
        applyStimulus(1'b0, 1'b0, 64'h77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77, 1, "flushDoneVictim");
        checkVal("flushDone outValidBefore", {63'd0, outValid}, 64'd1);
        flush = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        outReady = 1'b0;
        void'(expQ.pop_back());
        void'(tagQ.pop_back());
        checkVal("flushDone outValid", {63'd0, outValid}, 64'd0);
        checkVal("flushDone inReady", {63'd0, inReady}, 64'd1);

        for (int n = 0; n < 8; n++) begin
            ra = {$urandom, $urandom};
            rb = (n % 3 == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
            if (n % 4 == 1) rb = 64'(n + 1);
            rs = n[0];
            rw = n[1];
            refDiv(rs, rw, ra, rb, rq, rr, sp);
            applyStimulus(rs, rw, ra, rb, rq, rr, sp ? 1 : (rw ? LAT_WORD : LAT_FULL), "random");
            checkOutput(0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/div_iter_radix.md
Name: div_iter_radix

Overview:
- Parametrised iterative integer divider for the execute stage. Successor to the single-bit-per-cycle multi-cycle divider.
- Configurable datapath width (XLEN) and bits retired per cycle (RADIX_BITS).
- Full valid/ready handshake on both input and output sides, pipeline flush, and 1-cycle resolution of divide-by-zero and signed overflow.
- Supports DIV/DIVU/REM/REMU and word variants (DIVW etc.). Returns quotient and remainder together.

Parameters:
- XLEN, 64: operand/result width; must be even and ≥ 8.
- RADIX_BITS, 2: quotient bits resolved per CALC cycle; legal values 1, 2, 4; must divide XLEN/2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill the in-flight operation; synchronous
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- div_sign  in  1  1 = signed operation
- div_word  in  1  1 = operate on the low XLEN/2 bits; results sign-extended to XLEN
- rs1_data  in  XLEN  dividend
- rs2_data  in  XLEN  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- quot  out  XLEN  quotient
- rem  out  XLEN  remainder
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, quot=0, rem=0, counter=0.
- N = div_word ? XLEN/2 : XLEN. Word mode takes operands from the low N bits, sign- or zero-extended per div_sign.
- States are IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. Acceptance happens at the edge where in_valid & in_ready & ~flush.
  - On acceptance, latch div_sign, div_word, operand signs, and |rs1|, |rs2| (magnitudes in N bits).
  - Divide-by-zero (divisor==0): go to DONE.
    - quot = all ones (N bits, then sign-extended).
    - rem = dividend (N bits, then sign-extended).
  - Signed overflow (div_sign, dividend = min negative N-bit value, divisor = -1): go to DONE.
    - quot = dividend.
    - rem = 0.
  - Otherwise go to CALC with counter = N/RADIX_BITS.
- CALC:
  - Each cycle performs RADIX_BITS restoring-division steps on the magnitudes:
    - shift the partial remainder left by 1 and bring in the next dividend MSB;
    - trial-subtract the divisor;
    - keep the difference if it is non-negative, and set the quotient bit.
  - The partial remainder is N+1 bits wide.
  - Counter decrements each cycle. On the cycle where counter==1, go to FIX.
- FIX:
  - Negate the quotient if div_sign and the operand signs differ.
  - Negate the remainder if div_sign and the dividend is negative. The remainder takes the sign of the dividend.
  - In word mode, sign-extend both results from bit N-1 to XLEN. This applies to DIVUW/REMUW as well.
  - Go to DONE.
- DONE:
  - out_valid=1. quot and rem stay stable while out_valid & ~out_ready.
  - At the edge with out_ready=1, go to IDLE and deassert out_valid. A new request is accepted no earlier than the following cycle.
- Latency, counted from the acceptance edge:
  - Normal operation: out_valid is high in cycle N/RADIX_BITS + 2. XLEN=64, RADIX_BITS=2 gives 34 (full) or 18 (word).
  - Special cases: out_valid is high in cycle 1.
- flush:
  - In any state, the next state is IDLE and out_valid=0 on the next cycle. A result pending in DONE is discarded.
  - flush in IDLE together with in_valid: the request is not accepted.
  - flush has priority over out_ready.
- rst mid-operation: same effect as flush, and all state returns to reset values.
- quot and rem are registered outputs. Their values outside DONE are don't-care for the bench, but must not be X after reset.

Test Plan:
- Signed 64-bit division: rs1=-7 (0xFFFFFFFFFFFFFFF9), rs2=2, div_sign=1 -> quot=-3 (0x…FFFD), rem=-1. out_valid in cycle 34 with XLEN=64, RADIX_BITS=2.
- Unsigned division: rs1=0xFFFFFFFFFFFFFFFF, rs2=3, div_sign=0 -> quot=0x5555555555555555, rem=0.
- Special cases:
  - DIVU by zero, rs1=0x1234 -> quot=0xFFFFFFFFFFFFFFFF, rem=0x1234, out_valid in cycle 1.
  - Signed overflow, rs1=0x8000000000000000, rs2=-1 -> quot=0x8000000000000000, rem=0, out_valid in cycle 1.
- Word mode:
  - div_word=1, div_sign=1, rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF -> overflow path: quot=0xFFFFFFFF80000000, rem=0.
  - div_word=1, div_sign=0, rs1=0xABCD000000000064, rs2=7 -> quot=0x000000000000000E, rem=2, out_valid in cycle 18.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> quot/rem unchanged and in_ready=0 throughout. Then pulse out_ready -> IDLE next cycle.
- Flush/reset:
  - Assert flush in CALC cycle 10 -> IDLE next cycle, no out_valid. The next request, 100/7, yields quot=14, rem=2.
  - Repeat with rst instead of flush -> same outcome, and all outputs at reset values.
